// File: rtl/fifo_word_serializer_if.sv
// Handshake bundle between the FIFO read port, the serializer and the narrow beat consumer.
// m_parity exists only when FIFO_SER_PARITY_EN is defined.
interface fifo_word_serializer_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
`ifdef FIFO_SER_PARITY_EN
  logic             m_parity;
`endif

  modport master (
    input  fifo_empty, fifo_data, m_ready,
`ifdef FIFO_SER_PARITY_EN
    output m_parity,
`endif
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
`ifdef FIFO_SER_PARITY_EN
    input  m_parity,
`endif
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// FIFO drain stage: pops WIDTH-bit words, emits WIDTH/OUT_W beats (optional m_parity via FIFO_SER_PARITY_EN).
// Pop to first beat is 2 cycles; a stalled consumer holds the beat and blocks further pops.
module fifo_word_serializer #(
  parameter int WIDTH     = 16,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fifo_word_serializer_if.master bus
);
  localparam int N  = WIDTH / OUT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;

  logic             w_send;
  logic             w_last;
  logic [OUT_W-1:0] w_beat;
  logic [WIDTH-1:0] w_shift_next;

  assign w_send = (r_state == S_SEND);
  assign w_last = w_send && (r_cnt == LAST_IDX);

  // Consumed beats are shifted out with zero fill, so m_data reads 0 outside SEND.
  assign w_beat       = MSB_FIRST ? r_shift[WIDTH-1 -: OUT_W] : r_shift[OUT_W-1:0];
  assign w_shift_next = MSB_FIRST ? (r_shift << OUT_W) : (r_shift >> OUT_W);

  // Pop request is held off while reset is asserted even though the state already reads IDLE.
  assign bus.fifo_rd_en = rst_n && (r_state == S_IDLE) && !bus.fifo_empty;
  assign bus.m_valid    = w_send;
  assign bus.m_data     = w_beat;
  assign bus.m_last     = w_last;
`ifdef FIFO_SER_PARITY_EN
  assign bus.m_parity   = ^w_beat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.fifo_empty) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_shift <= bus.fifo_data;
          r_cnt   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (bus.m_ready) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
